alu_writeback_stage: RTL
========================

// Module: alu_writeback_stage
// PURPOSE
// - Stage directly downstream of the 8-bit ALU: accepts each ALU result plus Z/C/N/V flags.
// - Maintains the architectural status register.
// - Queues register-file writes in a small FIFO drained by a valid/ready writeback port.
// - Decouples ALU issue from register-file write availability.
// PARAMETERS
// - DEST_W      3  width of destination register index
// - FIFO_DEPTH  2  writeback FIFO entries; power of two, >= 2
// PORTS
// - clk          in   1        single clock; all state on rising edge
// - rst          in   1        asynchronous, active-high reset
// - in_valid     in   1        ALU result presented
// - in_ready     out  1        stage can accept; transfer when in_valid && in_ready
// - in_alu_op    in   4        ALU opcode that produced the result (0x0..0xF)
// - in_dest      in   DEST_W   destination register index
// - in_result    in   8        ALU result
// - in_zero, in_carry, in_negative, in_overflow  in  1 each   ALU flags
// - wb_valid     out  1        FIFO head valid
// - wb_ready     in   1        register file accepts; pop when wb_valid && wb_ready
// - wb_dest      out  DEST_W   head destination index
// - wb_data      out  8        head data
// - status       out  4        {N,Z,C,V} status register
// - trap         out  1        overflow trap pending (OVERFLOW_TRAP_EN only)
// - trap_op      out  4        opcode that trapped (OVERFLOW_TRAP_EN only)
// - trap_ack     in   1        clears trap (OVERFLOW_TRAP_EN only)
// BEHAVIOUR
// - Reset: FIFO empty, pointers 0, count 0, storage 0; wb_valid=0, wb_dest=0, wb_data=0.
//   status=4'b0000; in_ready=0 while rst is high.
// - Opcode classes:
//   - WRITE = 0x1..0xB, 0xD.
//   - FLAG_ONLY = 0xC (compare).
//   - NONE = 0x0, 0xE, 0xF.
// - On accept:
//   - WRITE: pushes {in_dest,in_result}.
//   - WRITE and FLAG_ONLY: load status <= {in_negative,in_zero,in_carry,in_overflow}.
//   - NONE: no push and no status change.
//   - Status is visible the cycle after accept.
// - in_ready = !full && state==RUN; combinational from registered state, not from wb_ready.
//   A full FIFO blocks all opcodes, including NONE and FLAG_ONLY.
// - Latency: a WRITE accepted into an empty FIFO raises wb_valid on the next cycle.
//   There is no same-cycle bypass.
// - wb_valid = (count != 0). wb_dest/wb_data hold the head entry and stay stable while
//   wb_valid && !wb_ready.
// - Simultaneous push and pop (not full): count unchanged, both pointers advance.
// - Full plus pop: in_ready stays 0 this cycle and rises the next cycle.
// - Pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH; never overflows or
//   underflows.
// - Reset mid-operation discards queued entries and any pending trap at once; no writeback
//   is issued.
// CONFIGURATION
// - Macro OVERFLOW_TRAP_EN defined:
//   - Adds ports trap, trap_op, trap_ack and FSM RUN/TRAP; reset state RUN, trap=0, trap_op=0.
//   - RUN->TRAP when accepting opcode 0x1, 0x2, 0x3 or 0xD with in_overflow=1.
//     The entry is still pushed and status still updated.
//   - TRAP: trap=1, trap_op=latched opcode, in_ready=0; the FIFO keeps draining.
//   - TRAP->RUN on the cycle after trap_ack=1 is sampled; trap_ack in RUN is ignored.
// - Macro not defined: no trap ports and no FSM (state is always RUN); overflow only
//   sets status[0].
// TESTING
// - Reset then idle: status=0, wb_valid=0, in_ready=1 after rst falls.
// - Single write: op=0x1, dest=3, result=0x80, N=1, wb_ready=1.
//   -> next cycle wb_valid=1, wb_dest=3, wb_data=0x80, status=4'b1000; pop the cycle after.
// - Backpressure: wb_ready=0 with 3 WRITEs (dest 1,2,3 / data 0x11,0x22,0x33).
//   -> first two accepted, in_ready=0 on the 3rd until wb_ready=1.
//   -> pops appear in order 0x11,0x22,0x33.
// - Compare/NOP: op=0xC with Z=1, C=0.
//   -> status=4'b0100, no wb_valid; then op=0x0 -> status unchanged.
// - Concurrent push/pop: one entry queued, wb_ready=1, push each cycle for 8 cycles.
//   -> count stays 1, in_ready stays 1, data order preserved across pointer wrap.
// - Trap (macro on): op=0x2, result=0x80, V=1.
//   -> entry written, status[0]=1, trap=1, trap_op=0x2, in_ready=0.
//   -> trap_ack pulse returns in_ready=1 the next cycle; rst during TRAP clears trap.

Source files
------------

// File: rtl/alu_writeback_stage_if.sv
// Interface bundling the ALU-result input handshake, the register-file
// writeback handshake and the status/trap outputs of alu_writeback_stage.
// The trap signals exist only when OVERFLOW_TRAP_EN is defined.
// slave  : the stage itself.
// master : whatever drives the ALU results and consumes the writebacks.
interface alu_writeback_stage_if #(
    parameter int DEST_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_alu_op;
    logic [DEST_W-1:0] in_dest;
    logic [7:0]        in_result;
    logic              in_zero;
    logic              in_carry;
    logic              in_negative;
    logic              in_overflow;
    logic              wb_valid;
    logic              wb_ready;
    logic [DEST_W-1:0] wb_dest;
    logic [7:0]        wb_data;
    logic [3:0]        status;
`ifdef OVERFLOW_TRAP_EN
    logic              trap;
    logic [3:0]        trap_op;
    logic              trap_ack;
`endif

    modport slave (
`ifdef OVERFLOW_TRAP_EN
        output trap,
        output trap_op,
        input  trap_ack,
`endif
        input  in_valid,
        output in_ready,
        input  in_alu_op,
        input  in_dest,
        input  in_result,
        input  in_zero,
        input  in_carry,
        input  in_negative,
        input  in_overflow,
        output wb_valid,
        input  wb_ready,
        output wb_dest,
        output wb_data,
        output status
    );

    modport master (
`ifdef OVERFLOW_TRAP_EN
        input  trap,
        input  trap_op,
        output trap_ack,
`endif
        output in_valid,
        input  in_ready,
        output in_alu_op,
        output in_dest,
        output in_result,
        output in_zero,
        output in_carry,
        output in_negative,
        output in_overflow,
        input  wb_valid,
        output wb_ready,
        input  wb_dest,
        input  wb_data,
        input  status
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: sits right after the 8-bit ALU. Accepted results that
// write a register are queued in a small FIFO drained by the valid/ready
// writeback port; writing and compare opcodes update the {N,Z,C,V} status.
// Optional feature macro: OVERFLOW_TRAP_EN adds an overflow trap FSM
// (RUN/TRAP) with trap/trap_op/trap_ack; without it the stage is always RUN.
module alu_writeback_stage #(
    parameter int DEST_W     = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_writeback_stage_if.slave  bus
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = DEST_W + 8;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         status_q, status_d;
    logic [ENTRY_W-1:0] entries [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head;

    logic full;
    logic run;
    logic in_ready_int;
    logic accept;
    logic push;
    logic pop;
    logic is_write;
    logic is_flag_only;
    logic is_trap_op;

    // Opcode classification: 0x1..0xB and 0xD write a register, 0xC only sets flags.
    always_comb begin
        is_write     = ((bus.in_alu_op >= 4'h1) && (bus.in_alu_op <= 4'hB)) ||
                       (bus.in_alu_op == 4'hD);
        is_flag_only = (bus.in_alu_op == 4'hC);
        is_trap_op   = (bus.in_alu_op == 4'h1) || (bus.in_alu_op == 4'h2) ||
                       (bus.in_alu_op == 4'h3) || (bus.in_alu_op == 4'hD);
    end

`ifdef OVERFLOW_TRAP_EN
    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t     state_q;
    logic       trap_q;
    logic [3:0] trap_op_q;

    assign run = (state_q == RUN);

    // Trap FSM: enter TRAP on an accepted signed-arith overflow, leave the cycle after trap_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            trap_q    <= 1'b0;
            trap_op_q <= 4'h0;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept && is_trap_op && bus.in_overflow) begin
                        state_q   <= TRAP;
                        trap_q    <= 1'b1;
                        trap_op_q <= bus.in_alu_op;
                    end
                end
                TRAP: begin
                    if (bus.trap_ack) begin
                        state_q <= RUN;
                        trap_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RUN;
                    trap_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trap    = trap_q;
    assign bus.trap_op = trap_op_q;
`else
    assign run = 1'b1;
`endif

    // Handshake: in_ready depends only on registered state (and reset), never on wb_ready.
    always_comb begin
        full         = (count_q == CNT_W'(FIFO_DEPTH));
        in_ready_int = !rst && !full && run;
        accept       = bus.in_valid && in_ready_int;
        push         = accept && is_write;
        pop          = (count_q != '0) && bus.wb_ready;
    end

    // Next-state for pointers, occupancy and status register.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        status_d = status_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (accept && (is_write || is_flag_only)) begin
            status_d = {bus.in_negative, bus.in_zero, bus.in_carry, bus.in_overflow};
        end
    end

    // Control/status registers; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            status_q <= 4'b0000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

    // FIFO storage: one register per entry, written when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_q, entry_d;

            // Capture {dest, result} on a push aimed at this slot.
            always_comb begin
                entry_d = entry_q;
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_d = {bus.in_dest, bus.in_result};
                end
            end

            // Entry register, cleared on reset so the head reads zero when empty.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign entries[gi] = entry_q;
        end
    endgenerate

    // Head entry is read straight from storage, so it holds steady while stalled.
    assign head         = entries[rd_ptr_q];
    assign bus.in_ready = in_ready_int;
    assign bus.wb_valid = (count_q != '0);
    assign bus.wb_dest  = head[ENTRY_W-1:8];
    assign bus.wb_data  = head[7:0];
    assign bus.status   = status_q;
endmodule
